// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor with valid/ready
// handshakes, full special-value handling, round-to-nearest-even and exception flags.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int SW = MAN_W + 5;   // XW plus carry
  localparam int unsigned SHIFT_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_INF  = {1'b0, EXP_ONES};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, next_state;

  logic [W-1:0]     a_q, b_q;
  logic             sub_q;
  logic [EXP_W:0]   exp_r;
  logic [XW-1:0]    big_x, small_x, norm_r;
  logic [SW-1:0]    sum_r;
  logic             same_r, zneg_r, sign_big_r, sign_r;

  // Operand classification
  logic               sign_a, sign_b;
  logic [EXP_W-1:0]   expf_a, expf_b, exp_a, exp_b;
  logic [MAN_W-1:0]   frac_a, frac_b;
  logic [MAN_W:0]     sig_a, sig_b;
  logic               nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, special;
  logic [W-1:0]       spec_res;
  logic [3:0]         spec_flags;

  always_comb begin
    sign_a  = a_q[W-1];
    sign_b  = b_q[W-1] ^ sub_q;
    expf_a  = a_q[W-2:MAN_W];
    expf_b  = b_q[W-2:MAN_W];
    frac_a  = a_q[MAN_W-1:0];
    frac_b  = b_q[MAN_W-1:0];
    exp_a   = (expf_a == '0) ? EXP_W'(1) : expf_a;
    exp_b   = (expf_b == '0) ? EXP_W'(1) : expf_b;
    sig_a   = {expf_a != '0, frac_a};
    sig_b   = {expf_b != '0, frac_b};
    nan_a   = (expf_a == EXP_ONES) && (frac_a != '0);
    nan_b   = (expf_b == EXP_ONES) && (frac_b != '0);
    snan_a  = nan_a && !frac_a[MAN_W-1];
    snan_b  = nan_b && !frac_b[MAN_W-1];
    inf_a   = (expf_a == EXP_ONES) && (frac_a == '0);
    inf_b   = (expf_b == EXP_ONES) && (frac_b == '0);
    special = nan_a | nan_b | inf_a | inf_b;

    spec_res   = QNAN;
    spec_flags = '0;
    if (nan_a || nan_b) begin
      spec_flags = {snan_a | snan_b, 3'b000};
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      spec_flags = 4'b1000;
    end else if (inf_a) begin
      spec_res = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_res = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // Alignment: operands are ordered by magnitude so the subtract never goes negative
  logic               a_ge;
  logic [EXP_W-1:0]   exp_big, exp_small, diff;
  logic [MAN_W:0]     sig_big, sig_small;
  logic [2*XW-1:0]    wide;
  logic [XW-1:0]      small_al;

  always_comb begin
    a_ge      = {exp_a, sig_a} >= {exp_b, sig_b};
    exp_big   = a_ge ? exp_a : exp_b;
    exp_small = a_ge ? exp_b : exp_a;
    sig_big   = a_ge ? sig_a : sig_b;
    sig_small = a_ge ? sig_b : sig_a;
    diff      = exp_big - exp_small;
    wide      = {sig_small, {(XW+3){1'b0}}} >> diff;
    if (32'(diff) > SHIFT_MAX)
      small_al = {{(XW-1){1'b0}}, |sig_small};
    else
      small_al = {wide[2*XW-1:XW+1], wide[XW] | (|wide[XW-1:0])};
  end

  logic [SW-1:0] sum_n;

  always_comb begin
    if (same_r)
      sum_n = {1'b0, big_x} + {1'b0, small_x};
    else
      sum_n = {1'b0, big_x} - {1'b0, small_x};
  end

  // Normalisation; left shift is capped so the exponent never drops below 1
  int unsigned    lzc, lim, sh;
  logic [XW-1:0]  norm_n;
  logic [EXP_W:0] exp_n;

  always_comb begin
    lzc = XW;
    for (int unsigned i = 0; i < XW; i++)
      if (sum_r[i]) lzc = XW - 1 - i;
    lim = 32'(exp_r) - 1;
    sh  = (lzc > lim) ? lim : lzc;
    if (sum_r[SW-1]) begin
      norm_n = {sum_r[SW-1:2], |sum_r[1:0]};
      exp_n  = exp_r + 1'b1;
    end else begin
      norm_n = sum_r[XW-1:0] << sh;
      exp_n  = exp_r - (EXP_W+1)'(sh);
    end
  end

  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] rnd;
  logic             inc, hid, nx;
  logic [MAN_W-1:0] frac_n;
  logic [EXP_W:0]   exp_f;
  logic [EXP_W-1:0] exp_field;
  logic [W-1:0]     res_n;
  logic [3:0]       flags_n;

  always_comb begin
    mant = norm_r[XW-1:3];
    inc  = norm_r[2] & (norm_r[1] | norm_r[0] | mant[0]);
    rnd  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    if (rnd[MAN_W+1]) begin
      hid    = 1'b1;
      frac_n = rnd[MAN_W:1];
      exp_f  = exp_r + 1'b1;
    end else begin
      hid    = rnd[MAN_W];
      frac_n = rnd[MAN_W-1:0];
      exp_f  = exp_r;
    end
    nx        = |norm_r[2:0];
    exp_field = hid ? exp_f[EXP_W-1:0] : '0;
    if (exp_f >= EXP_INF) begin
      res_n   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      flags_n = 4'b0101;
    end else begin
      res_n   = {sign_r, exp_field, frac_n};
      flags_n = {2'b00, !hid && nx && (norm_r != '0), nx};
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = UNPACK;
      UNPACK:  next_state = special ? DONE : ALIGN;
      ALIGN:   next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    next_state = ROUND;
      ROUND:   next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // out_valid is registered, so it rises one cycle after DONE is entered
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      exp_r      <= '0;
      big_x      <= '0;
      small_x    <= '0;
      norm_r     <= '0;
      sum_r      <= '0;
      same_r     <= 1'b0;
      zneg_r     <= 1'b0;
      sign_big_r <= 1'b0;
      sign_r     <= 1'b0;
      result     <= '0;
      flags      <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          sub_q <= op_sub;
          flags <= '0;
        end
        UNPACK: if (special) begin
          result <= spec_res;
          flags  <= spec_flags;
        end
        ALIGN: begin
          exp_r      <= {1'b0, exp_big};
          big_x      <= {sig_big, 3'b000};
          small_x    <= small_al;
          same_r     <= (sign_a == sign_b);
          zneg_r     <= sign_a & sign_b;
          sign_big_r <= a_ge ? sign_a : sign_b;
        end
        ADD: begin
          sum_r  <= sum_n;
          sign_r <= (sum_n == '0) ? zneg_r : sign_big_r;
        end
        NORM: begin
          norm_r <= norm_n;
          exp_r  <= exp_n;
        end
        ROUND: begin
          result <= res_n;
          flags  <= flags_n;
        end
        DONE: out_valid <= !(out_valid && out_ready);
        default: ;
      endcase
    end
  end

endmodule
